// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the hazard/flush sequencer.
// FSM states and the saturating perf-counter helper.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LDUSE,
        ST_MEMWAIT,
        ST_FLUSH
    } pc_state_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard sequencer.
// master = pipeline side, slave = pipeline_ctrl.
interface pipeline_ctrl_if #(
    parameter int REGADDR_WIDTH = 5
);
    logic [REGADDR_WIDTH-1:0] id_rs_addr;
    logic                     id_rs_used;
    logic [REGADDR_WIDTH-1:0] id_rt_addr;
    logic                     id_rt_used;
    logic                     id_is_branch;
    logic [REGADDR_WIDTH-1:0] ex_wb_reg_addr;
    logic                     ex_is_load;
    logic                     mem_busy;
    logic                     exc_req;
    logic [31:0]              exc_vector;

    logic                     stall_if;
    logic                     stall_id;
    logic                     stall_ex;
    logic                     clear_id;
    logic                     clear_ex;
    logic                     in_delay_slot;
    logic                     pc_redirect_valid;
    logic [31:0]              pc_redirect;
    logic [31:0]              stall_cycles;

    modport master (
        output id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
        output id_is_branch, ex_wb_reg_addr, ex_is_load,
        output mem_busy, exc_req, exc_vector,
        input  stall_if, stall_id, stall_ex, clear_id, clear_ex,
        input  in_delay_slot, pc_redirect_valid, pc_redirect,
        input  stall_cycles
    );

    modport slave (
        input  id_rs_addr, id_rs_used, id_rt_addr, id_rt_used,
        input  id_is_branch, ex_wb_reg_addr, ex_is_load,
        input  mem_busy, exc_req, exc_vector,
        output stall_if, stall_id, stall_ex, clear_id, clear_ex,
        output in_delay_slot, pc_redirect_valid, pc_redirect,
        output stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use comparator: EX load writes a register the ID instr reads.
// Register 0 is never a real destination.
module load_use_detect #(
    parameter int REGADDR_WIDTH = 5
) (
    input  logic [REGADDR_WIDTH-1:0] rs_addr,
    input  logic                     rs_used,
    input  logic [REGADDR_WIDTH-1:0] rt_addr,
    input  logic                     rt_used,
    input  logic [REGADDR_WIDTH-1:0] wb_addr,
    input  logic                     is_load,
    output logic                     hit
);
    logic rs_hit;
    logic rt_hit;

    assign rs_hit = rs_used && (rs_addr == wb_addr);
    assign rt_hit = rt_used && (rt_addr == wb_addr);
    assign hit = is_load && (wb_addr != '0) && (rs_hit || rt_hit);
endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/flush sequencer: load-use bubbles, memory freeze,
// exception flush with registered PC redirect, delay-slot flag.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REGADDR_WIDTH = 5,
    parameter int FLUSH_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    pipeline_ctrl_if.slave     bus
);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    pc_state_t   state;
    pc_state_t   state_nxt;
    logic [FW-1:0] flush_cnt;
    logic [FW-1:0] flush_nxt;

    logic hit;
    logic s_if, s_id, s_ex;
    logic c_id, c_ex;

    logic        ds_q;
    logic        prv_q;
    logic [31:0] pc_q;
    logic [31:0] sc_q;

    load_use_detect #(
        .REGADDR_WIDTH(REGADDR_WIDTH)
    ) u_lud (
        .rs_addr (bus.id_rs_addr),
        .rs_used (bus.id_rs_used),
        .rt_addr (bus.id_rt_addr),
        .rt_used (bus.id_rt_used),
        .wb_addr (bus.ex_wb_reg_addr),
        .is_load (bus.ex_is_load),
        .hit     (hit)
    );

    always_comb begin
        state_nxt = state;
        flush_nxt = flush_cnt;
        s_if = 1'b0;
        s_id = 1'b0;
        s_ex = 1'b0;
        c_id = 1'b0;
        c_ex = 1'b0;
        if (bus.exc_req) begin
            c_id = 1'b1;
            c_ex = 1'b1;
            flush_nxt = FW'(FLUSH_CYCLES - 1);
            state_nxt = ST_FLUSH;
        end else if (state == ST_FLUSH) begin
            c_id = (flush_cnt != '0);
            c_ex = (flush_cnt != '0);
            if (bus.mem_busy) begin
                // Freeze fetch only; the flush count waits for memory.
                s_if = 1'b1;
            end else if (flush_cnt > FW'(1)) begin
                flush_nxt = flush_cnt - FW'(1);
            end else begin
                flush_nxt = '0;
                state_nxt = ST_RUN;
            end
        end else if (bus.mem_busy) begin
            s_if = 1'b1;
            s_id = 1'b1;
            s_ex = 1'b1;
            state_nxt = ST_MEMWAIT;
        end else if (hit) begin
            s_if = 1'b1;
            c_id = 1'b1;
            state_nxt = ST_LDUSE;
        end else begin
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prv_q <= 1'b0;
            pc_q  <= '0;
        end else begin
            prv_q <= bus.exc_req;
            if (bus.exc_req)
                pc_q <= bus.exc_vector;
        end
    end

    // A bubble leaves the slot instruction pending, so the flag holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ds_q <= 1'b0;
        else if (bus.exc_req || state == ST_FLUSH)
            ds_q <= 1'b0;
        else if (!s_id && !c_id)
            ds_q <= bus.id_is_branch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sc_q <= '0;
        else if (s_if)
            sc_q <= sat_inc(sc_q);
    end

    assign bus.stall_if          = s_if & ~rst;
    assign bus.stall_id          = s_id & ~rst;
    assign bus.stall_ex          = s_ex & ~rst;
    assign bus.clear_id          = c_id & ~rst;
    assign bus.clear_ex          = c_ex & ~rst;
    assign bus.in_delay_slot     = ds_q;
    assign bus.pc_redirect_valid = prv_q;
    assign bus.pc_redirect       = pc_q;
    assign bus.stall_cycles      = sc_q;
endmodule
